// File: rtl/control_sequencer.sv
// control_sequencer
//   Microcode-free T-state sequencer for a small accumulator machine.
//   Every instruction takes six T-states on a registered one-hot ring.
//   T1-T3 fetch the instruction. T4-T6 execute it, decoded from IR_opcode.
//   HLT parks the ring in a sticky HALT state.
//
// Ports
//   CLK          system clock, rising-edge active
//   RESET        asynchronous active-low reset
//   run          1 advances one T-state per clock, 0 freezes the sequencer
//   IR_opcode    opcode field of the instruction register
//   PC_en        program counter increment
//   PC_OE        program counter drives the bus
//   PC_WE        program counter loads from the bus
//   MAR_in       MAR loads from the bus
//   RAM_out      RAM drives the bus
//   IR_in        IR loads from the bus
//   IR_out       IR operand field drives the bus
//   A_in         A loads from the bus
//   A_out        A drives the bus
//   B_in         B loads from the bus
//   ALU_out      ALU drives the bus
//   sub          ALU subtract select
//   OUT_in       output register loads from the bus
//   tstate       one-hot T-state (bit0 = T1 .. bit5 = T6), all zero when halted
//   halted       sticky halt flag
//   instr_count  completed-instruction counter, wraps at 255
//
// state | meaning
// ------+----------------------------------------------------------
// T1    | fetch: PC onto bus, latch into MAR
// T2    | fetch: increment PC
// T3    | fetch: RAM onto bus, latch into IR
// T4    | execute step 1; HLT leaves the ring here
// T5    | execute step 2
// T6    | execute step 3; leaving T6 counts one completed instruction
// HALT  | parked until reset, no strobes, tstate = 000000

module control_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       run,
  input  logic [3:0] IR_opcode,
  output logic       PC_en,
  output logic       PC_OE,
  output logic       PC_WE,
  output logic       MAR_in,
  output logic       RAM_out,
  output logic       IR_in,
  output logic       IR_out,
  output logic       A_in,
  output logic       A_out,
  output logic       B_in,
  output logic       ALU_out,
  output logic       sub,
  output logic       OUT_in,
  output logic [5:0] tstate,
  output logic       halted,
  output logic [7:0] instr_count
);

  typedef enum logic [5:0] {
    T1   = 6'b000001,
    T2   = 6'b000010,
    T3   = 6'b000100,
    T4   = 6'b001000,
    T5   = 6'b010000,
    T6   = 6'b100000,
    HALT = 6'b000000
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t     state_q;
  state_t     state_d;
  logic       halted_q;
  logic       halted_d;
  logic [7:0] count_q;
  logic [7:0] count_d;
  logic       strobe_en;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= T1;
      halted_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  // Strobes are also qualified by RESET so they drop the moment reset is
  // asserted, not at the next clock edge.
  assign strobe_en = RESET & run & ~halted_q;

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    count_d  = count_q;
    PC_en    = 1'b0;
    PC_OE    = 1'b0;
    PC_WE    = 1'b0;
    MAR_in   = 1'b0;
    RAM_out  = 1'b0;
    IR_in    = 1'b0;
    IR_out   = 1'b0;
    A_in     = 1'b0;
    A_out    = 1'b0;
    B_in     = 1'b0;
    ALU_out  = 1'b0;
    sub      = 1'b0;
    OUT_in   = 1'b0;

    if (run && !halted_q) begin
      case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: state_d = T4;
        T4: begin
          if (IR_opcode == OP_HLT) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = T5;
          end
        end
        T5: state_d = T6;
        T6: begin
          state_d = T1;
          count_d = count_q + 8'd1;
        end
        // HALT without the halted flag cannot be reached; restart the fetch.
        default: state_d = T1;
      endcase
    end

    if (strobe_en) begin
      case (state_q)
        T1: begin
          PC_OE  = 1'b1;
          MAR_in = 1'b1;
        end
        T2: PC_en = 1'b1;
        T3: begin
          RAM_out = 1'b1;
          IR_in   = 1'b1;
        end
        T4: begin
          case (IR_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              IR_out = 1'b1;
              MAR_in = 1'b1;
            end
            OP_JMP: begin
              IR_out = 1'b1;
              PC_WE  = 1'b1;
            end
            OP_OUT: begin
              A_out  = 1'b1;
              OUT_in = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (IR_opcode)
            OP_LDA: begin
              RAM_out = 1'b1;
              A_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              RAM_out = 1'b1;
              B_in    = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (IR_opcode == OP_ADD || IR_opcode == OP_SUB) begin
            ALU_out = 1'b1;
            A_in    = 1'b1;
            sub     = (IR_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate      = state_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic       CLK;
  logic       RESET;
  logic       run;
  logic [3:0] IR_opcode;
  logic       PC_en, PC_OE, PC_WE, MAR_in, RAM_out, IR_in, IR_out;
  logic       A_in, A_out, B_in, ALU_out, sub, OUT_in;
  logic [5:0] tstate;
  logic       halted;
  logic [7:0] instr_count;

  control_sequencer dut (
    .CLK(CLK), .RESET(RESET), .run(run), .IR_opcode(IR_opcode),
    .PC_en(PC_en), .PC_OE(PC_OE), .PC_WE(PC_WE), .MAR_in(MAR_in),
    .RAM_out(RAM_out), .IR_in(IR_in), .IR_out(IR_out), .A_in(A_in),
    .A_out(A_out), .B_in(B_in), .ALU_out(ALU_out), .sub(sub),
    .OUT_in(OUT_in), .tstate(tstate), .halted(halted),
    .instr_count(instr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe vector bit order, MSB first:
  // PC_en PC_OE PC_WE MAR_in RAM_out IR_in IR_out A_in A_out B_in ALU_out sub OUT_in
  wire [12:0] strb = {PC_en, PC_OE, PC_WE, MAR_in, RAM_out, IR_in, IR_out,
                      A_in, A_out, B_in, ALU_out, sub, OUT_in};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: instruction phase index 0..5, halt flag, count.
  int   m_phase  = 0;
  bit   m_halted = 1'b0;
  int   m_count  = 0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_phase  <= 0;
      m_halted <= 1'b0;
      m_count  <= 0;
    end else if (run && !m_halted) begin
      if (m_phase == 3 && IR_opcode == 4'hF) m_halted <= 1'b1;
      else if (m_phase == 5) begin
        m_phase <= 0;
        m_count <= (m_count + 1) % 256;
      end else m_phase <= m_phase + 1;
    end
  end

  function automatic logic [12:0] model_strb(input int phase, input logic [3:0] op);
    logic [12:0] s;
    s = '0;
    case (phase)
      0: begin s[11] = 1; s[9] = 1; end                     // PC_OE MAR_in
      1: s[12] = 1;                                         // PC_en
      2: begin s[8] = 1; s[7] = 1; end                      // RAM_out IR_in
      3: begin
        if (op <= 4'd2) begin s[6] = 1; s[9] = 1; end       // IR_out MAR_in
        else if (op == 4'd3) begin s[6] = 1; s[10] = 1; end // IR_out PC_WE
        else if (op == 4'hE) begin s[4] = 1; s[0] = 1; end  // A_out OUT_in
      end
      4: begin
        if (op == 4'd0) begin s[8] = 1; s[5] = 1; end       // RAM_out A_in
        else if (op == 4'd1 || op == 4'd2) begin s[8] = 1; s[3] = 1; end
      end
      5: begin
        if (op == 4'd1 || op == 4'd2) begin s[2] = 1; s[5] = 1; s[1] = (op == 4'd2); end
      end
      default: ;
    endcase
    return s;
  endfunction

  always @(negedge CLK) begin
    logic [12:0] es;
    logic [5:0]  et;
    logic [4:0]  drivers;
    es = (RESET && run && !m_halted) ? model_strb(m_phase, IR_opcode) : 13'd0;
    et = m_halted ? 6'd0 : 6'(1 << m_phase);
    chk("cyc_tstate", 32'(tstate), 32'(et));
    chk("cyc_halted", 32'(halted), 32'(m_halted));
    chk("cyc_count", 32'(instr_count), 32'(m_count));
    chk("cyc_strobes", 32'(strb), 32'(es));
    drivers = {PC_OE, RAM_out, IR_out, A_out, ALU_out};
    chk("cyc_pc_conflict", 32'(PC_en & PC_WE), 32'd0);
    chk("cyc_one_driver", 32'($countones(drivers) <= 1), 32'd1);
  end

  logic [12:0] seen [6];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #1;
    RESET = 1'b1;
  endtask

  // Entered at T1 just after an edge; leaves at the next T1.
  // The opcode is scrambled during fetch, which must not matter.
  task automatic run_instr(input logic [3:0] op);
    for (int p = 0; p < 6; p++) begin
      IR_opcode = (p < 3) ? 4'($urandom_range(0, 15)) : op;
      #1;
      seen[p] = strb;
      step();
    end
  endtask

  initial begin
    RESET = 1'b1;
    run = 1'b0;
    IR_opcode = 4'h0;
    #1 RESET = 1'b0;
    #2;
    chk("rst_tstate", 32'(tstate), 32'h01);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    run = 1'b1;
    #1;
    chk("rst_strobes_run", 32'(strb), 32'h0);
    step();
    step();
    RESET = 1'b1;

    // LDA
    run_instr(4'h0);
    chk("lda_t1", 32'(seen[0]), 32'hA00);
    chk("lda_t2", 32'(seen[1]), 32'h1000);
    chk("lda_t3", 32'(seen[2]), 32'h180);
    chk("lda_t4", 32'(seen[3]), 32'h240);
    chk("lda_t5", 32'(seen[4]), 32'h120);
    chk("lda_t6", 32'(seen[5]), 32'h0);
    chk("lda_count", 32'(instr_count), 32'd1);
    chk("lda_tstate", 32'(tstate), 32'h01);

    // ADD then SUB from a fresh reset
    do_reset();
    run_instr(4'h1);
    chk("add_t5", 32'(seen[4]), 32'h108);
    chk("add_t6", 32'(seen[5]), 32'h24);
    run_instr(4'h2);
    chk("sub_t6", 32'(seen[5]), 32'h26);
    chk("addsub_count", 32'(instr_count), 32'd2);

    // JMP, OUT
    run_instr(4'h3);
    chk("jmp_t2", 32'(seen[1]), 32'h1000);
    chk("jmp_t4", 32'(seen[3]), 32'h440);
    chk("jmp_t5t6", 32'(seen[4] | seen[5]), 32'h0);
    run_instr(4'hE);
    chk("out_t4", 32'(seen[3]), 32'h11);
    chk("out_t5t6", 32'(seen[4] | seen[5]), 32'h0);

    // Freeze in T3
    IR_opcode = 4'h5;
    step();
    step();
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("frz_tstate", 32'(tstate), 32'h04);
      chk("frz_strobes", 32'(strb), 32'h0);
      step();
    end
    run = 1'b1;
    #1;
    chk("frz_resume", 32'(strb), 32'h180);
    repeat (4) step();
    chk("nop_count", 32'(instr_count), 32'd5);

    // HLT
    IR_opcode = 4'hF;
    repeat (3) step();
    #1;
    chk("hlt_t4", 32'(strb), 32'h0);
    step();
    chk("hlt_halted", 32'(halted), 32'h1);
    chk("hlt_tstate", 32'(tstate), 32'h0);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      step();
      chk("hlt_strobes", 32'(strb), 32'h0);
      chk("hlt_count", 32'(instr_count), 32'd5);
      chk("hlt_sticky", 32'(halted), 32'h1);
    end

    // 256 NOPs wrap the counter, then async reset in T5
    run = 1'b1;
    IR_opcode = 4'h5;
    do_reset();
    repeat (255 * 6) step();
    chk("wrap_255", 32'(instr_count), 32'd255);
    repeat (6) step();
    chk("wrap_0", 32'(instr_count), 32'd0);
    chk("wrap_tstate", 32'(tstate), 32'h01);
    repeat (4) step();
    chk("pre_rst_t5", 32'(tstate), 32'h10);
    #1 RESET = 1'b0;
    #1;
    chk("arst_tstate", 32'(tstate), 32'h01);
    chk("arst_strobes", 32'(strb), 32'h0);
    chk("arst_count", 32'(instr_count), 32'd0);
    step();
    RESET = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port run, input, 1 bit: 1 advances the sequencer; 0 freezes it.
REQ-004 SHALL have port IR_opcode, input, 4 bits: opcode field from the instruction register.
REQ-005 SHALL have output ports PC_en, PC_OE and PC_WE, 1 bit each: program counter increment, drive-to-bus and load-from-bus.
REQ-006 SHALL have output ports MAR_in, RAM_out, IR_in, IR_out, A_in, A_out, B_in, ALU_out, sub and OUT_in, 1 bit each: datapath load and drive strobes.
REQ-007 SHALL have port tstate, output, 6 bits: one-hot T-state, where bit0 is T1 and bit5 is T6.
REQ-008 SHALL have port halted, output, 1 bit: 1 when the HALT state is reached.
REQ-009 SHALL have port instr_count, output, 8 bits: number of completed instructions.

Function
REQ-010 SHALL hold state in a registered one-hot ring T1->T2->...->T6->T1, plus a registered HALT flag.
REQ-011 SHALL advance exactly one T-state per rising CLK edge when run=1; when run=0, tstate, halted and instr_count SHALL hold.
REQ-012 SHALL decode all strobes combinationally from tstate and IR_opcode.
REQ-013 SHALL force all strobes to 0 whenever run=0 or halted=1.
REQ-014 SHALL perform the fetch in T1-T3 for every opcode:
- T1: PC_OE and MAR_in.
- T2: PC_en.
- T3: RAM_out and IR_in.
REQ-015 SHALL execute opcode 0000 (LDA) as:
- T4: IR_out and MAR_in.
- T5: RAM_out and A_in.
- T6: no strobes.
REQ-016 SHALL execute opcode 0001 (ADD) as:
- T4: IR_out and MAR_in.
- T5: RAM_out and B_in.
- T6: ALU_out and A_in, with sub=0.
REQ-017 SHALL execute opcode 0010 (SUB) identically to ADD, except sub=1 in T6.
REQ-018 SHALL execute opcode 0011 (JMP) as:
- T4: IR_out and PC_WE.
- T5 and T6: no strobes.
REQ-019 SHALL execute opcode 1110 (OUT) as:
- T4: A_out and OUT_in.
- T5 and T6: no strobes.
REQ-020 SHALL treat all other opcodes, except 1111, as NOP: no strobes in T4-T6.
REQ-021 SHALL, for opcode 1111 (HLT), assert no strobes in T4; the T4->T5 edge SHALL set halted=1 and clear tstate to 000000.
REQ-022 SHALL keep halted=1 sticky until RESET, regardless of run.
REQ-023 SHALL never assert PC_en together with PC_WE, never assert more than one bus driver (PC_OE, RAM_out, IR_out, A_out, ALU_out), and never assert sub outside ADD/SUB T6.
REQ-024 SHALL increment instr_count on each T6->T1 transition, wrapping 255->0.
REQ-025 SHALL NOT count HLT as a completed instruction.
REQ-026 SHALL allow IR_opcode changes during T1-T3 without affecting the state sequence; only its value in T4-T6 matters.

Reset
REQ-027 SHALL, while RESET=0, immediately and regardless of CLK, force tstate=000001 (T1), halted=0, instr_count=0, and every strobe to 0.
REQ-028 SHALL, on RESET deassertion, begin at T1 with fetch strobes PC_OE and MAR_in valid once run=1.
REQ-029 SHALL, when RESET is asserted mid-instruction (any T-state or HALT), abandon that instruction with no partial strobes after assertion and leave instr_count=0.

Verification
REQ-030 Bench SHALL cover: reset release, run=1, IR_opcode=0000 -> T1 PC_OE+MAR_in, T2 PC_en, T3 RAM_out+IR_in, T4 IR_out+MAR_in, T5 RAM_out+A_in, T6 none; then instr_count=1 and tstate=000001.
REQ-031 Bench SHALL cover: ADD then SUB back-to-back -> T6 ALU_out+A_in with sub=0 then sub=1; instr_count=2 after 12 cycles.
REQ-032 Bench SHALL cover: JMP -> PC_WE only in T4 and never coincident with PC_en; OUT -> A_out+OUT_in only in T4.
REQ-033 Bench SHALL cover: HLT -> halted=1 after the T4 edge, tstate=000000, all strobes 0 for 20 further cycles with run toggling, instr_count unchanged.
REQ-034 Bench SHALL cover: run=0 held 5 cycles in T3 -> tstate stays 000100 with strobes 0; run=1 resumes at T3 with RAM_out+IR_in.
REQ-035 Bench SHALL cover: 256 NOP instructions (opcode 0101) -> instr_count wraps to 0; then RESET=0 asserted asynchronously in T5 -> tstate=000001 and strobes 0 before the next CLK edge.
